// File: rtl/switch_input_latch_if.sv
// Board input bundle between the switch/key pins, the CPU control unit and the
// switch input latch; master = board/CPU side, slave = the latch.
interface switch_input_latch_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] switches_raw;
  logic             enter_raw;
  logic             cu_inSignal;
  logic [WIDTH-1:0] switches_out;
  logic             in_valid;
  logic             in_stall;
  logic             overrun;

  modport master (
    output switches_raw, enter_raw, cu_inSignal,
    input  switches_out, in_valid, in_stall, overrun
  );

  modport slave (
    input  switches_raw, enter_raw, cu_inSignal,
    output switches_out, in_valid, in_stall, overrun
  );
endinterface

// File: rtl/switch_input_latch.sv
// Synchronises the slide switches, debounces the enter key (INLATCH_DEBOUNCE_EN)
// and hands one switch snapshot per key press to the CPU with a valid/consume handshake.
module switch_input_latch #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_WIDTH       = 20
) (
  input logic                 clock,
  input logic                 reset,
  switch_input_latch_if.slave bus
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  if (DEBOUNCE_CYCLES < 2 ||
      longint'(DEBOUNCE_CYCLES) > ((longint'(1) << CNT_WIDTH) - 1)) begin : g_cfg_check
    $error("switch_input_latch: DEBOUNCE_CYCLES out of range for CNT_WIDTH");
  end

  logic             key_p0, key_p1;
  logic [WIDTH-1:0] sw_p0, sw_p1;
  logic             primed, armed;
  logic             deb_level;
  logic             accept;
  logic             press;
  state_t           state, state_nxt;
  logic             valid_c, consume_c, stall_c;
  logic [WIDTH-1:0] snap;
  logic             ovr;

  // Stage p0/p1: two-flop synchronisers; the key idles released (1)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_p0 <= 1'b1;
      key_p1 <= 1'b1;
      sw_p0  <= '0;
      sw_p1  <= '0;
    end else begin
      key_p0 <= bus.enter_raw;
      key_p1 <= key_p0;
      sw_p0  <= bus.switches_raw;
      sw_p1  <= sw_p0;
    end
  end

  // A key held through reset must be seen released before a press counts;
  // primed keeps the reset-filled synchroniser from arming on the first edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      primed <= 1'b0;
      armed  <= 1'b0;
    end else begin
      primed <= 1'b1;
      if (primed && key_p0 && key_p1)
        armed <= 1'b1;
    end
  end

`ifdef INLATCH_DEBOUNCE_EN
  localparam logic [CNT_WIDTH-1:0] TERM = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [CNT_WIDTH-1:0] cnt;

  assign accept = (key_p1 != deb_level) && (cnt == TERM);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      deb_level <= 1'b1;
    end else if (key_p1 == deb_level) begin
      cnt <= '0;
    end else if (accept) begin
      cnt       <= '0;
      deb_level <= key_p1;
    end else begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end
`else
  assign accept = (key_p1 != deb_level);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) deb_level <= 1'b1;
    else        deb_level <= key_p1;
  end
`endif

  // Only the 1->0 acceptance is a press; releases are silently absorbed
  assign press = accept & ~key_p1 & armed;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= EMPTY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY:   if (press) state_nxt = FULL;
      FULL:    if (consume_c && !press) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    valid_c   = (state == FULL);
    consume_c = bus.cu_inSignal & valid_c;
    stall_c   = bus.cu_inSignal & ~valid_c;
  end

  // A press that coincides with a consume is not an overrun: the CPU got the old value
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      snap <= '0;
      ovr  <= 1'b0;
    end else if (press) begin
      snap <= sw_p1;
      if (valid_c && !consume_c)
        ovr <= 1'b1;
    end
  end

  assign bus.switches_out = snap;
  assign bus.in_valid     = valid_c;
  assign bus.in_stall     = stall_c;
  assign bus.overrun      = ovr;

endmodule

// File: tb/tb_switch_input_latch.sv
// Bench for switch_input_latch: table-driven scenarios, hand-written corner
// sequences and randomized traffic, all checked against a cycle-level reference model.
module tb_switch_input_latch;

  localparam int WIDTH = 16;
  localparam int DC    = 4;
`ifdef INLATCH_DEBOUNCE_EN
  localparam int DC_EFF = DC;
`else
  localparam int DC_EFF = 1;
`endif
  localparam int LAT = 2 + DC_EFF;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  switch_input_latch_if #(.WIDTH(WIDTH)) bus ();

  switch_input_latch #(
    .WIDTH(WIDTH), .DEBOUNCE_CYCLES(DC), .CNT_WIDTH(8)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  // Reference model: synchronised history, run length of disagreement, handshake state
  logic             m_ks1, m_ks2;
  logic [WIDTH-1:0] m_ss1, m_ss2;
  logic             m_deb, m_armed, m_valid, m_ovr;
  logic [WIDTH-1:0] m_sw;
  int               m_run, m_edges;

  typedef struct {
    logic [WIDTH-1:0] sw;
    logic             enter;
    logic             cu;
    int               hold;
    logic             exp_valid;
    logic [WIDTH-1:0] exp_sw;
    logic             exp_ovr;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ks1 = 1'b1; m_ks2 = 1'b1; m_ss1 = '0; m_ss2 = '0;
    m_deb = 1'b1; m_run = 0; m_edges = 0; m_armed = 1'b0;
    m_valid = 1'b0; m_sw = '0; m_ovr = 1'b0;
  endtask

  task automatic model_edge();
    logic accept, press, consume, arm_now;
    if (!reset) begin
      model_reset();
    end else begin
      accept = 1'b0;
      // the key level changes after DC_EFF consecutive cycles of disagreement
      if (m_ks2 == m_deb) m_run = 0;
      else if (m_run == DC_EFF - 1) begin accept = 1'b1; m_run = 0; end
      else m_run++;
      press   = accept && !m_ks2 && m_armed;
      consume = bus.cu_inSignal && m_valid;
      arm_now = (m_edges >= 1) && m_ks1 && m_ks2;
      if (accept) m_deb = m_ks2;
      if (press) begin
        if (m_valid && !consume) m_ovr = 1'b1;
        m_sw    = m_ss2;
        m_valid = 1'b1;
      end else if (consume) begin
        m_valid = 1'b0;
      end
      if (arm_now) m_armed = 1'b1;
      m_ks2 = m_ks1; m_ks1 = bus.enter_raw;
      m_ss2 = m_ss1; m_ss1 = bus.switches_raw;
      if (m_edges < 2) m_edges++;
    end
  endtask

  task automatic cycle();
    #2;
    chk("model_stall", bus.in_stall, bus.cu_inSignal & ~m_valid);
    @(posedge clock);
    model_edge();
    #1;
    chk("model_valid", bus.in_valid, m_valid);
    chk("model_sw", bus.switches_out, m_sw);
    chk("model_ovr", bus.overrun, m_ovr);
  endtask

  task automatic drive(input logic [WIDTH-1:0] sw, input logic enter, input logic cu);
    bus.switches_raw = sw;
    bus.enter_raw    = enter;
    bus.cu_inSignal  = cu;
  endtask

  task automatic do_reset();
    drive('0, 1'b1, 1'b0);
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", bus.in_valid, 1'b0);
    chk("rst_sw", bus.switches_out, '0);
    chk("rst_ovr", bus.overrun, 1'b0);
    repeat (2) cycle();
    reset = 1'b1;
    repeat (4) cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{16'h00A5, 1'b0, 1'b0, LAT - 1, 1'b0, 16'h0000, 1'b0};
    tbl[1] = '{16'h00A5, 1'b0, 1'b0, 1,       1'b1, 16'h00A5, 1'b0};
    tbl[2] = '{16'h00A5, 1'b0, 1'b0, 5,       1'b1, 16'h00A5, 1'b0};
    tbl[3] = '{16'h00A5, 1'b0, 1'b1, 1,       1'b0, 16'h00A5, 1'b0};
    tbl[4] = '{16'h00A5, 1'b1, 1'b0, LAT + 2, 1'b0, 16'h00A5, 1'b0};
    tbl[5] = '{16'h0001, 1'b0, 1'b0, LAT,     1'b1, 16'h0001, 1'b0};
    tbl[6] = '{16'h0001, 1'b1, 1'b0, LAT + 2, 1'b1, 16'h0001, 1'b0};
    tbl[7] = '{16'h0002, 1'b0, 1'b0, LAT,     1'b1, 16'h0002, 1'b1};
    tbl[8] = '{16'h0002, 1'b1, 1'b1, 1,       1'b0, 16'h0002, 1'b1};
    tbl[9] = '{16'h0002, 1'b1, 1'b0, LAT + 2, 1'b0, 16'h0002, 1'b1};

    drive('0, 1'b1, 1'b0);
    model_reset();
    #1;
    chk("init_valid", bus.in_valid, 1'b0);
    chk("init_sw", bus.switches_out, '0);
    chk("init_ovr", bus.overrun, 1'b0);
    chk("init_stall", bus.in_stall, 1'b0);
    @(posedge clock);
    #1;
    do_reset();

    // Capture latency, held key, consume, overrun
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].sw, tbl[i].enter, tbl[i].cu);
      repeat (tbl[i].hold) cycle();
      chk($sformatf("tbl%0d_valid", i), bus.in_valid, tbl[i].exp_valid);
      chk($sformatf("tbl%0d_sw", i), bus.switches_out, tbl[i].exp_sw);
      chk($sformatf("tbl%0d_ovr", i), bus.overrun, tbl[i].exp_ovr);
    end

`ifdef INLATCH_DEBOUNCE_EN
    // Bounce rejection
    do_reset();
    drive(16'h0BAD, 1'b0, 1'b0); repeat (3) cycle();
    drive(16'h0BAD, 1'b1, 1'b0); repeat (1) cycle();
    drive(16'h0BAD, 1'b0, 1'b0); repeat (3) cycle();
    drive(16'h0BAD, 1'b1, 1'b0); repeat (LAT + 2) cycle();
    chk("bounce_valid", bus.in_valid, 1'b0);
    drive(16'h0BAD, 1'b0, 1'b0); repeat (6) cycle();
    chk("bounce_hold_valid", bus.in_valid, 1'b1);
    chk("bounce_hold_sw", bus.switches_out, 16'h0BAD);
    chk("bounce_hold_ovr", bus.overrun, 1'b0);
    drive(16'h0BAD, 1'b1, 1'b0); repeat (LAT + 2) cycle();
`endif

    // Stall released by a press, consume in the same cycle
    do_reset();
    drive('0, 1'b1, 1'b1);
    #1;
    chk("stall_empty", bus.in_stall, 1'b1);
    drive(16'h1234, 1'b0, 1'b1);
    repeat (LAT) cycle();
    chk("stall_done_valid", bus.in_valid, 1'b1);
    chk("stall_done_stall", bus.in_stall, 1'b0);
    cycle();
    chk("stall_after_valid", bus.in_valid, 1'b0);
    chk("stall_after_sw", bus.switches_out, 16'h1234);
    drive(16'h1234, 1'b1, 1'b0); repeat (LAT + 2) cycle();

    // Press and consume on the same edge
    do_reset();
    drive(16'h0003, 1'b0, 1'b0); repeat (LAT) cycle();
    drive(16'h0003, 1'b1, 1'b0); repeat (LAT + 2) cycle();
    chk("simul_pre_valid", bus.in_valid, 1'b1);
    drive(16'h0004, 1'b0, 1'b0); repeat (LAT - 1) cycle();
    drive(16'h0004, 1'b0, 1'b1); cycle();
    chk("simul_valid", bus.in_valid, 1'b1);
    chk("simul_sw", bus.switches_out, 16'h0004);
    chk("simul_ovr", bus.overrun, 1'b0);
    drive(16'h0004, 1'b1, 1'b0); repeat (LAT + 2) cycle();

    // Reset mid-debounce with the key held through reset release
    do_reset();
    drive(16'h0055, 1'b0, 1'b0); repeat (LAT) cycle();
    drive(16'h0055, 1'b1, 1'b0); repeat (LAT + 2) cycle();
    drive(16'h0066, 1'b0, 1'b0); repeat (4) cycle();
`ifdef INLATCH_DEBOUNCE_EN
    chk("midrst_cnt_before", dut.cnt, 8'd2);
`endif
    reset = 1'b0;
    model_reset();
    #1;
    chk("midrst_valid", bus.in_valid, 1'b0);
    chk("midrst_sw", bus.switches_out, '0);
    chk("midrst_ovr", bus.overrun, 1'b0);
`ifdef INLATCH_DEBOUNCE_EN
    chk("midrst_cnt", dut.cnt, 8'd0);
`endif
    repeat (2) cycle();
    reset = 1'b1;
    repeat (LAT + 10) cycle();
    chk("held_through_reset", bus.in_valid, 1'b0);
    drive(16'h0077, 1'b1, 1'b0); repeat (LAT + 2) cycle();
    drive(16'h0077, 1'b0, 1'b0); repeat (LAT) cycle();
    chk("repress_valid", bus.in_valid, 1'b1);
    chk("repress_sw", bus.switches_out, 16'h0077);

    // Randomized key activity, switch noise and IN strobes
    for (int b = 0; b < 60; b++) begin
      logic key;
      int   len;
      key = 1'($urandom_range(0, 1));
      len = $urandom_range(1, LAT + 3);
      for (int c = 0; c < len; c++) begin
        drive(WIDTH'($urandom), key, ($urandom_range(0, 3) == 0));
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
